// File: rtl/tpu_pkg.sv
// Shared types and helpers for the TPU weight path.
// Used by the weight loader and its row unpacker.
package tpu_pkg;

  typedef enum logic [1:0] {
    WL_IDLE,
    WL_LOAD,
    WL_FINISH
  } wl_state_e;

  function automatic int row_bits(input int array_size);
    return 2 * array_size;
  endfunction

endpackage

// File: rtl/tpu_row_unpacker.sv
// Holds one packed input word and emits its ROW_BITS slices,
// lowest first, one per consume strobe.
module tpu_row_unpacker #(
  parameter int IN_WIDTH = 32,
  parameter int ROW_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                load,
  input  logic [IN_WIDTH-1:0] in_data,
  input  logic                consume,
  input  logic                last,
  output logic                hv,
  output logic [ROW_BITS-1:0] row
);

  localparam int RPW = IN_WIDTH / ROW_BITS;
  localparam int SW  = (RPW > 1) ? $clog2(RPW) : 1;

  logic [IN_WIDTH-1:0] hold;
  logic [SW-1:0]       slice;
  logic                end_slice;

  // last lets a partial final word drop its unused upper slices
  assign end_slice = last || (slice == SW'(RPW - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold  <= '0;
      hv    <= 1'b0;
      slice <= '0;
    end else if (flush) begin
      hv    <= 1'b0;
      slice <= '0;
    end else if (load) begin
      hold  <= in_data;
      hv    <= 1'b1;
      slice <= '0;
    end else if (consume) begin
      if (end_slice) begin
        hv    <= 1'b0;
        slice <= '0;
      end else begin
        slice <= slice + SW'(1);
      end
    end
  end

  assign row = hold[slice*ROW_BITS +: ROW_BITS];

endmodule

// File: rtl/tpu_weight_loader.sv
// Streams packed ternary weight words into the shadow bank
// of the weight buffer, one row per cycle.
module tpu_weight_loader
  import tpu_pkg::*;
#(
  parameter int ARRAY_SIZE = 8,
  parameter int MAX_K      = 256,
  parameter int ADDR_WIDTH = 16,
  parameter int IN_WIDTH   = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [$clog2(MAX_K):0]          num_rows,
  input  logic                            auto_swap,
  input  logic                            abort,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [IN_WIDTH-1:0]             in_data,
  output logic                            wr_en,
  output logic [ADDR_WIDTH-1:0]           wr_addr,
  output logic [row_bits(ARRAY_SIZE)-1:0] wr_data,
  output logic                            swap_banks,
  output logic                            busy,
  output logic                            done,
  output logic                            err
);

  localparam int RB = row_bits(ARRAY_SIZE);
  localparam int CW = $clog2(MAX_K) + 1;
  localparam int AW = CW - 1;

  wl_state_e     state, state_n;
  logic [CW-1:0] row_cnt, row_cnt_n;
  logic [CW-1:0] num_q, num_q_n;
  logic          swap_q, swap_q_n;
  logic          hv;
  logic          load;
  logic          last;
  logic          legal;
  logic [RB-1:0] row;

  assign legal    = (num_rows != '0) && (num_rows <= CW'(MAX_K));
  assign last     = (row_cnt == num_q - CW'(1));
  assign in_ready = (state == WL_LOAD) && !hv;
  assign load     = in_valid && in_ready && !abort;
  assign busy     = (state != WL_IDLE);
  assign wr_en    = hv;
  assign wr_data  = row;

  always_comb begin
    wr_addr         = '0;
    wr_addr[AW-1:0] = row_cnt[AW-1:0];
  end

  tpu_row_unpacker #(
    .IN_WIDTH (IN_WIDTH),
    .ROW_BITS (RB)
  ) u_unpack (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (abort),
    .load    (load),
    .in_data (in_data),
    .consume (hv),
    .last    (last),
    .hv      (hv),
    .row     (row)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= WL_IDLE;
      row_cnt <= '0;
      num_q   <= '0;
      swap_q  <= 1'b0;
    end else begin
      state   <= state_n;
      row_cnt <= row_cnt_n;
      num_q   <= num_q_n;
      swap_q  <= swap_q_n;
    end
  end

  always_comb begin
    state_n    = state;
    row_cnt_n  = row_cnt;
    num_q_n    = num_q;
    swap_q_n   = swap_q;
    err        = 1'b0;
    done       = 1'b0;
    swap_banks = 1'b0;
    if (abort) begin
      state_n   = WL_IDLE;
      row_cnt_n = '0;
    end else begin
      unique case (state)
        WL_IDLE: begin
          if (start) begin
            if (legal) begin
              state_n   = WL_LOAD;
              row_cnt_n = '0;
              num_q_n   = num_rows;
              swap_q_n  = auto_swap;
            end else begin
              err = 1'b1;
            end
          end
        end
        WL_LOAD: begin
          if (hv) begin
            row_cnt_n = row_cnt + CW'(1);
            if (last) state_n = WL_FINISH;
          end
        end
        WL_FINISH: begin
          done       = 1'b1;
          swap_banks = swap_q;
          state_n    = WL_IDLE;
        end
        default: state_n = WL_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_weight_loader.sv
// Directed bench for tpu_weight_loader at default parameters.
// Writes are logged at the falling edge and checked per scenario.
module tb_tpu_weight_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [8:0]  num_rows;
  logic        auto_swap;
  logic        abort;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        swap_banks;
  logic        busy;
  logic        done;
  logic        err;

  int nchk = 0;
  int nerr = 0;

  tpu_weight_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_rows   (num_rows),
    .auto_swap  (auto_swap),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .swap_banks (swap_banks),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  logic [15:0] la[$];
  logic [15:0] ld[$];
  int          lc[$];
  int          done_cnt = 0;
  int          swap_cnt = 0;
  int          err_cnt  = 0;
  int          done_cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (wr_en) begin
      la.push_back(wr_addr);
      ld.push_back(wr_data);
      lc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (swap_banks) swap_cnt++;
    if (err) err_cnt++;
  end

  task automatic clear_log();
    la.delete();
    ld.delete();
    lc.delete();
  endtask

  task automatic do_start(input int n, input bit sw);
    @(posedge clk); #1;
    start     = 1'b1;
    num_rows  = n[8:0];
    auto_swap = sw;
    @(posedge clk); #1;
    start     = 1'b0;
    num_rows  = '0;
    auto_swap = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
      end
    end
    in_valid = 1'b0;
    in_data  = 32'hdead_beef;
    nchk++;
    if (!ok) begin
      nerr++;
      $display("FAIL handshake: word %h accepted=%0b required=1", d, ok);
    end
  endtask

  // returns at the falling edge where done is high (or after the bound)
  task automatic wait_done(output bit found);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (done) found = 1'b1;
    end
    nchk++;
    if (!found) begin
      nerr++;
      $display("FAIL done_timeout: done seen=0 required=1");
    end
  endtask

  task automatic check_log(input string tag, input int n,
                           input logic [15:0] exp_d[4]);
    nchk++;
    if (la.size() !== n) begin
      nerr++;
      $display("FAIL %s_count: writes=%0d required=%0d", tag, la.size(), n);
    end
    for (int i = 0; i < n && i < la.size(); i++) begin
      nchk++;
      if (la[i] !== 16'(i) || ld[i] !== exp_d[i]) begin
        nerr++;
        $display("FAIL %s_wr%0d: addr=%h data=%h required addr=%h data=%h",
                 tag, i, la[i], ld[i], 16'(i), exp_d[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    nchk++;
    if ({wr_en, in_ready, busy, done, swap_banks, err, wr_addr, wr_data} !== '0) begin
      nerr++;
      $display("FAIL reset_outputs: wr_en=%b rdy=%b busy=%b addr=%h data=%h required all 0",
               wr_en, in_ready, busy, wr_addr, wr_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    nchk++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL reset_idle: in_ready=%b busy=%b required 0 0", in_ready, busy);
    end
  endtask

  task automatic test_full_job();
    logic [15:0] e[4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    bit f;
    int d0, s0;
    clear_log();
    d0 = done_cnt;
    s0 = swap_cnt;
    do_start(4, 1'b1);
    nchk++;
    if (busy !== 1'b1) begin
      nerr++;
      $display("FAIL full_busy: busy=%b required=1", busy);
    end
    send_word(32'h2222_1111);
    send_word(32'h4444_3333);
    wait_done(f);
    nchk++;
    if (f && swap_banks !== 1'b1) begin
      nerr++;
      $display("FAIL full_swap: swap_banks=%b required=1 with done", swap_banks);
    end
    @(negedge clk); #1;
    nchk++;
    if (busy !== 1'b0) begin
      nerr++;
      $display("FAIL full_busy_fall: busy=%b required=0", busy);
    end
    check_log("full", 4, e);
    nchk++;
    if (done_cnt - d0 !== 1 || swap_cnt - s0 !== 1) begin
      nerr++;
      $display("FAIL full_pulses: done=%0d swap=%0d required 1 1",
               done_cnt - d0, swap_cnt - s0);
    end
    if (lc.size() == 4) begin
      nchk++;
      if (lc[1] !== lc[0] + 1 || lc[3] !== lc[2] + 1 || done_cyc !== lc[3] + 1) begin
        nerr++;
        $display("FAIL full_timing: wr cycles %0d %0d %0d %0d done %0d required pairs adjacent, done=last+1",
                 lc[0], lc[1], lc[2], lc[3], done_cyc);
      end
    end
  endtask

  task automatic test_partial();
    logic [15:0] e[4] = '{16'h1111, 16'h2222, 16'h3333, 16'h0000};
    bit f;
    int s0;
    clear_log();
    s0 = swap_cnt;
    do_start(3, 1'b0);
    send_word(32'h2222_1111);
    send_word(32'h4444_3333);
    wait_done(f);
    nchk++;
    if (f && swap_banks !== 1'b0) begin
      nerr++;
      $display("FAIL partial_swap: swap_banks=%b required=0", swap_banks);
    end
    repeat (3) @(negedge clk);
    #1;
    check_log("partial", 3, e);
    nchk++;
    if (swap_cnt !== s0 || in_ready !== 1'b0) begin
      nerr++;
      $display("FAIL partial_after: swaps=%0d in_ready=%b required %0d 0",
               swap_cnt - s0, in_ready, 0);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] e[4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    bit f;
    clear_log();
    do_start(4, 1'b0);
    send_word(32'h2222_1111);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      nchk++;
      if (in_ready !== 1'b1 || wr_en !== 1'b0) begin
        nerr++;
        $display("FAIL gap%0d: in_ready=%b wr_en=%b required 1 0", i, in_ready, wr_en);
      end
    end
    @(posedge clk); #1;
    send_word(32'h4444_3333);
    wait_done(f);
    #1;
    check_log("bp", 4, e);
  endtask

  task automatic test_illegal();
    int e0;
    clear_log();
    e0 = err_cnt;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      start    = 1'b1;
      num_rows = (k == 0) ? 9'd0 : 9'd257;
      @(negedge clk);
      nchk++;
      if (err !== 1'b1 || busy !== 1'b0) begin
        nerr++;
        $display("FAIL illegal%0d: err=%b busy=%b required 1 0", k, err, busy);
      end
      @(posedge clk); #1;
      start    = 1'b0;
      num_rows = '0;
      @(negedge clk);
      nchk++;
      if (err !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
        nerr++;
        $display("FAIL illegal%0d_after: err=%b busy=%b rdy=%b required 0 0 0",
                 k, err, busy, in_ready);
      end
    end
    #1;
    nchk++;
    if (err_cnt - e0 !== 2 || la.size() !== 0) begin
      nerr++;
      $display("FAIL illegal_totals: err pulses=%0d writes=%0d required 2 0",
               err_cnt - e0, la.size());
    end
  endtask

  task automatic test_abort();
    logic [15:0] e1[4] = '{16'h1111, 16'h2222, 16'h0000, 16'h0000};
    logic [15:0] e2[4] = '{16'h5555, 16'h6666, 16'h0000, 16'h0000};
    bit f;
    int d0, s0;
    clear_log();
    d0 = done_cnt;
    s0 = swap_cnt;
    do_start(8, 1'b1);
    send_word(32'h2222_1111);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h8888_7777;
    @(posedge clk); #1;
    abort    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      nchk++;
      if (wr_en !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
        nerr++;
        $display("FAIL abort_idle%0d: wr_en=%b busy=%b rdy=%b required 0 0 0",
                 i, wr_en, busy, in_ready);
      end
    end
    #1;
    check_log("abort", 2, e1);
    nchk++;
    if (done_cnt !== d0 || swap_cnt !== s0) begin
      nerr++;
      $display("FAIL abort_pulses: done=%0d swap=%0d required 0 0",
               done_cnt - d0, swap_cnt - s0);
    end
    clear_log();
    do_start(2, 1'b1);
    send_word(32'h6666_5555);
    wait_done(f);
    #1;
    check_log("restart", 2, e2);
  endtask

  task automatic test_reset_mid_job();
    clear_log();
    do_start(8, 1'b1);
    send_word(32'h2222_1111);
    nchk++;
    if (wr_en !== 1'b1) begin
      nerr++;
      $display("FAIL rst_pre: wr_en=%b required=1", wr_en);
    end
    #2;
    rst_n = 1'b0;
    #1;
    nchk++;
    if ({wr_en, in_ready, busy, done, swap_banks, err, wr_addr, wr_data} !== '0) begin
      nerr++;
      $display("FAIL rst_async: wr_en=%b rdy=%b busy=%b addr=%h data=%h required all 0",
               wr_en, in_ready, busy, wr_addr, wr_data);
    end
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      nchk++;
      if (in_ready !== 1'b0 || wr_en !== 1'b0 || busy !== 1'b0) begin
        nerr++;
        $display("FAIL rst_after%0d: rdy=%b wr_en=%b busy=%b required 0 0 0",
                 i, in_ready, wr_en, busy);
      end
    end
    #1;
    nchk++;
    if (la.size() !== 0) begin
      nerr++;
      $display("FAIL rst_writes: writes=%0d required=0", la.size());
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    num_rows  = '0;
    auto_swap = 1'b0;
    abort     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    test_reset();
    test_full_job();
    test_partial();
    test_backpressure();
    test_illegal();
    test_abort();
    test_reset_mid_job();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
